// File: rtl/wishbone_to_ahb_if.sv
// Bundle of the Wishbone classic slave port and the AHB-Lite master port
// seen by the wishbone_to_ahb bridge.
// Optional feature macro: WB2AHB_ERR_EN adds the wb_err signal.
// Handshake: a Wishbone request is valid while wb_cyc & wb_stb are high and
// is answered by a one-cycle wb_ack (or wb_err); on AHB an address phase is
// accepted and a data phase completes on a cycle with HREADY = 1.
interface wishbone_to_ahb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [3:0]            wb_sel;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [DATA_WIDTH-1:0] wb_dat_w;
  logic [DATA_WIDTH-1:0] wb_dat_r;
  logic                  wb_ack;
`ifdef WB2AHB_ERR_EN
  logic                  wb_err;
`endif
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  // Bridge view: Wishbone slave, AHB-Lite master.
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w,
    input  HRDATA, HREADY, HRESP,
    output wb_dat_r, wb_ack,
`ifdef WB2AHB_ERR_EN
    output wb_err,
`endif
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  // Environment view: Wishbone initiator plus AHB-Lite responder.
  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w,
    output HRDATA, HREADY, HRESP,
    input  wb_dat_r, wb_ack,
`ifdef WB2AHB_ERR_EN
    input  wb_err,
`endif
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge, one transfer at a time.
// wb_sel is turned into HSIZE and HADDR[1:0]; illegal patterns never reach AHB.
// Optional feature macro: WB2AHB_ERR_EN -- when defined, errors pulse wb_err
// instead of wb_ack; when undefined, errors pulse wb_ack with zero read data.
module wishbone_to_ahb #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic             clk,
  input  logic             rst_n,
  wishbone_to_ahb_if.slave bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [2:0]            hsize_q;
  logic                  hwrite_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aborted_q;
`ifdef WB2AHB_ERR_EN
  logic                  err_q;
`endif
  logic                  sel_legal;
  logic [2:0]            sel_size;
  logic [1:0]            sel_lo;
  logic                  req;
  logic                  done_pulse;

  assign req = bus.wb_cyc & bus.wb_stb;

  // Decode the byte selects into an AHB size and low address bits.
  always_comb begin
    sel_legal = 1'b1;
    sel_size  = 3'b000;
    sel_lo    = 2'b00;
    case (bus.wb_sel)
      4'b1111: sel_size = 3'b010;
      4'b0011: sel_size = 3'b001;
      4'b1100: begin sel_size = 3'b001; sel_lo = 2'b10; end
      4'b0001: sel_lo = 2'b00;
      4'b0010: sel_lo = 2'b01;
      4'b0100: sel_lo = 2'b10;
      4'b1000: sel_lo = 2'b11;
      default: sel_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic: address phase, data phase, then one response cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req) state_n = sel_legal ? S_ADDR : S_DONE;
      S_ADDR: if (bus.HREADY) state_n = S_DATA;
      S_DATA: if (bus.HREADY) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Request capture, abort tracking and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haddr_q   <= '0;
      hsize_q   <= 3'b000;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
`ifdef WB2AHB_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req) begin
          aborted_q <= 1'b0;
          if (sel_legal) begin
            haddr_q  <= {bus.wb_adr[ADDR_WIDTH-1:2], sel_lo};
            hsize_q  <= sel_size;
            hwrite_q <= bus.wb_we;
            hwdata_q <= bus.wb_dat_w;
`ifdef WB2AHB_ERR_EN
            err_q    <= 1'b0;
`endif
          end else begin
            rdata_q  <= '0;
`ifdef WB2AHB_ERR_EN
            err_q    <= 1'b1;
`endif
          end
        end
        S_ADDR: if (!bus.wb_cyc) aborted_q <= 1'b1;
        S_DATA: begin
          if (!bus.wb_cyc) aborted_q <= 1'b1;
          if (bus.HREADY) begin
            if (bus.HRESP) rdata_q <= '0;
            else if (!hwrite_q) rdata_q <= bus.HRDATA;
`ifdef WB2AHB_ERR_EN
            err_q <= bus.HRESP;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Response pulse is suppressed when the initiator walked away mid-transfer.
  assign done_pulse = (state == S_DONE) && !aborted_q;
`ifdef WB2AHB_ERR_EN
  assign bus.wb_ack = done_pulse & ~err_q;
  assign bus.wb_err = done_pulse & err_q;
`else
  assign bus.wb_ack = done_pulse;
`endif
  assign bus.wb_dat_r   = rdata_q;
  assign bus.HTRANS     = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign bus.HADDR      = haddr_q;
  assign bus.HSIZE      = hsize_q;
  assign bus.HWRITE     = hwrite_q;
  assign bus.HWDATA     = hwdata_q;
  assign bus.HBURST     = 3'b000;
  assign bus.HPROT      = HPROT_VAL;
  assign bus.HMASTLOCK  = 1'b0;
  assign dbg_state      = state;

endmodule

// File: doc/wishbone_to_ahb.md
# wishbone_to_ahb

- Bridge from a Wishbone classic slave port to an AHB-Lite master port, one transfer at a time.
- Connects Wishbone initiators (Controller-side test logic, DMA-style masters) to AHB-Lite peripherals and memories on the core side.
- It is the opposite direction of the `ahb_to_wishbone` adapter used by the core wrappers.
- Converts `wb_sel` into `HSIZE`/`HADDR[1:0]` and returns read data and an error indication to the Wishbone side.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width on both sides.
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `HPROT_VAL`, 4'b0011, constant value driven on `HPROT`.

Ports:
- `clk`  in  1  single clock for both sides.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_cyc`, `wb_stb`, `wb_we`  in  1 each  Wishbone cycle, strobe and write enable.
- `wb_sel`  in  4  byte selects.
- `wb_adr`  in  ADDR_WIDTH  byte address.
- `wb_dat_w`  in  32  write data.
- `wb_dat_r`  out  32  read data, valid while `wb_ack` is high.
- `wb_ack`  out  1  single-cycle acknowledge.
- `wb_err`  out  1  single-cycle error; present only with `WB2AHB_ERR_EN`.
- `HADDR`  out  ADDR_WIDTH.
- `HTRANS`  out  2.
- `HWRITE`  out  1.
- `HSIZE`  out  3.
- `HBURST`  out  3  constant 3'b000 (SINGLE).
- `HPROT`  out  4  constant `HPROT_VAL`.
- `HMASTLOCK`  out  1  constant 0.
- `HWDATA`  out  32.
- `HRDATA`  in  32.
- `HREADY`  in  1.
- `HRESP`  in  1.

## Operation
FSM states: IDLE, ADDR, DATA, DONE.

- **IDLE**
  - `HTRANS`=IDLE (2'b00).
  - On `wb_cyc & wb_stb` with a legal `wb_sel`: register address, size, write and write data, then go to ADDR.
  - Illegal `wb_sel`: go straight to DONE with the error flag set; no AHB transfer is issued.
- **Legal `wb_sel` decode** (`HSIZE`, `HADDR[1:0]`; `HADDR` upper bits come from `wb_adr`, whose low bits are ignored):
  - 4'b1111 → word, 00.
  - 4'b0011 → half, 00.
  - 4'b1100 → half, 10.
  - 4'b0001, 4'b0010, 4'b0100, 4'b1000 → byte, 00 / 01 / 10 / 11.
  - Every other pattern, including 4'b0000, is illegal.
- **ADDR**
  - `HTRANS`=NONSEQ (2'b10); `HADDR`, `HSIZE`, `HWRITE` driven from registers.
  - Hold until `HREADY`=1, then go to DATA.
- **DATA**
  - `HTRANS`=IDLE; `HWDATA` = registered write data, held stable for the whole data phase.
  - `HREADY`=1 & `HRESP`=0: capture `HRDATA` (reads only), go to DONE with no error.
  - `HREADY`=1 & `HRESP`=1: go to DONE with the error flag set; rdata is 0.
  - `HREADY`=0: wait. The first cycle of a two-cycle error response (`HRESP`=1, `HREADY`=0) is simply waited through.
- **DONE**
  - Asserts `wb_ack`, or `wb_err`, for exactly one cycle, then returns to IDLE.
  - A request present in the cycle after DONE is a new transfer.
- **Abort:** if `wb_cyc` drops while in ADDR or DATA, the AHB transfer still completes. DONE is entered but the ack/err pulse is suppressed.
- Only one outstanding transfer; no address pipelining.

## Timing
- Reset values:
  - `HTRANS`=0, `HADDR`=0, `HWRITE`=0, `HSIZE`=0, `HWDATA`=0.
  - `wb_ack`=0, `wb_err`=0, `wb_dat_r`=0.
  - State = IDLE.
- Zero-wait-state latency, with the strobe sampled at edge 0:
  - NONSEQ on the bus in cycle 1.
  - Data phase in cycle 2.
  - `wb_ack` high in cycle 3.
- Each `HREADY`=0 cycle in ADDR or DATA adds one cycle.
- Illegal `wb_sel`: ack/err in the cycle after sampling.
- Reset asserted mid-transfer: all outputs return to their reset values asynchronously. No AHB completion and no Wishbone ack are produced.
- `wb_dat_r` is valid only in the ack cycle. It is held, not cleared, afterwards.

## Configuration
`WB2AHB_ERR_EN`:
- **Defined:** the `wb_err` port exists. Error responses and illegal `wb_sel` pulse `wb_err` instead of `wb_ack`.
- **Undefined:** no `wb_err` port. Errors pulse `wb_ack` with `wb_dat_r`=32'h0, and write errors are silently dropped.

## Test plan
- **Word read, zero wait:** `wb_adr`=0x100, sel=4'hF, `HRDATA`=0xCAFEBABE → NONSEQ to `HADDR`=0x100 with `HSIZE`=2; `wb_ack` 3 cycles after the strobe with `wb_dat_r`=0xCAFEBABE.
- **Byte write:** adr=0x203, sel=4'b1000, dat=0xAB000000 → `HADDR`=0x203, `HSIZE`=0, `HWRITE`=1, `HWDATA`=0xAB000000 in the data phase; single ack.
- **Wait states:** `HREADY` low 2 cycles in ADDR and 3 cycles in DATA → ack at cycle 8; `HTRANS`/`HADDR` stable while stalled; `HWDATA` stable throughout.
- **Error response:** two-cycle error (`HRESP`=1, `HREADY`=0, then `HRESP`=1, `HREADY`=1) → one `wb_err` pulse with the macro defined; `wb_ack` with `wb_dat_r`=0 without it.
- **Illegal sel 4'b0110:** no NONSEQ ever appears; error/ack next cycle.
- **Abort and reset:** `wb_cyc` dropped in DATA → AHB transfer completes with no ack. `rst_n` low in ADDR → `HTRANS`=0 immediately and the FSM restarts from IDLE.
